// File: rtl/objects_mux_n_if.sv
// Pixel bus between the drawing objects / game logic and the priority mux.
// Carries the per-layer requests and colours in, and the registered pixel and game state out.
interface objects_mux_n_if #(
   parameter int NUM_LAYERS = 8,
   parameter int RGB_W      = 8
);
   localparam int SEL_W = $clog2(NUM_LAYERS + 1);

   // No backpressure on this bus: each drawing request acts as a per-pixel valid
   // that is consumed on every clk edge; the mux is always ready.
   logic [NUM_LAYERS-1:0]       layerDR;
   logic [NUM_LAYERS*RGB_W-1:0] layerRGB;
   logic [NUM_LAYERS-1:0]       layerMask;
   logic [RGB_W-1:0]            backGroundRGB;
   logic                        screenDR;
   logic [RGB_W-1:0]            screenRGB;
   logic                        gameover;
   logic                        restart;
   logic                        startOfFrame;
   logic [RGB_W-1:0]            RGBOut;
   logic [SEL_W-1:0]            layerSel;
   logic [1:0]                  gameState;

   modport master (
      output layerDR, layerRGB, layerMask, backGroundRGB,
      output screenDR, screenRGB, gameover, restart, startOfFrame,
      input  RGBOut, layerSel, gameState
   );

   modport slave (
      input  layerDR, layerRGB, layerMask, backGroundRGB,
      input  screenDR, screenRGB, gameover, restart, startOfFrame,
      output RGBOut, layerSel, gameState
   );
endinterface

// File: rtl/objects_mux_n.sv
// N-layer priority video mux with a PLAY -> FLASH -> SCREEN game-over sequencer.
// One cycle of latency from sampled layer inputs to RGBOut/layerSel.
module objects_mux_n #(
   parameter int               NUM_LAYERS   = 8,
   parameter int               RGB_W        = 8,
   parameter int               FLASH_FRAMES = 60,
   parameter int               FLASH_PERIOD = 8,
   parameter logic [RGB_W-1:0] FLASH_RGB    = {RGB_W{1'b1}}
) (
   input  logic            clk,
   input  logic            reset,
   objects_mux_n_if.slave  bus
);
   localparam int SEL_W = $clog2(NUM_LAYERS + 1);
   localparam int FC_W  = $clog2(FLASH_FRAMES + 1);
   localparam int PC_W  = $clog2(FLASH_PERIOD + 1);

   localparam logic [SEL_W-1:0] SEL_NONE    = SEL_W'(NUM_LAYERS);
   localparam logic [FC_W-1:0]  FRAME_LAST  = FC_W'(FLASH_FRAMES - 1);
   localparam logic [PC_W-1:0]  PERIOD_LAST = PC_W'(FLASH_PERIOD - 1);

   typedef enum logic [1:0] {
      ST_PLAY   = 2'd0,
      ST_FLASH  = 2'd1,
      ST_SCREEN = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [FC_W-1:0]  frame_q, frame_d;
   logic [PC_W-1:0]  period_q, period_d;
   logic             flash_q, flash_d;
   logic [RGB_W-1:0] rgb_q, rgb_d;
   logic [SEL_W-1:0] sel_q, sel_d;

   logic             win_hit;
   logic [SEL_W-1:0] win_idx;
   logic [RGB_W-1:0] win_rgb;

   // Scan from the lowest priority up so the lowest enabled index is left standing.
   always_comb begin
      win_hit = 1'b0;
      win_idx = SEL_NONE;
      win_rgb = '0;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (bus.layerDR[i] && bus.layerMask[i]) begin
            win_hit = 1'b1;
            win_idx = SEL_W'(i);
            win_rgb = bus.layerRGB[i*RGB_W +: RGB_W];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      frame_d  = frame_q;
      period_d = period_q;
      flash_d  = flash_q;
      rgb_d    = win_hit ? win_rgb : bus.backGroundRGB;
      sel_d    = win_idx;

      case (state_q)
         ST_PLAY: begin
            frame_d  = '0;
            period_d = '0;
            flash_d  = 1'b1;
            if (bus.gameover) begin
               state_d = ST_FLASH;
            end
         end

         ST_FLASH: begin
            // Only object pixels flash; the background keeps its own colour.
            if (win_hit && flash_q) begin
               rgb_d = FLASH_RGB;
            end
            if (bus.startOfFrame) begin
               if (frame_q == FRAME_LAST) begin
                  state_d = ST_SCREEN;
               end else begin
                  frame_d = frame_q + FC_W'(1);
               end
               if (period_q == PERIOD_LAST) begin
                  period_d = '0;
                  flash_d  = ~flash_q;
               end else begin
                  period_d = period_q + PC_W'(1);
               end
            end
         end

         ST_SCREEN: begin
            rgb_d    = bus.screenDR ? bus.screenRGB : bus.backGroundRGB;
            sel_d    = SEL_NONE;
            frame_d  = '0;
            period_d = '0;
            flash_d  = 1'b1;
            if (bus.restart) begin
               state_d = ST_PLAY;
            end
         end

         default: begin
            state_d  = ST_PLAY;
            frame_d  = '0;
            period_d = '0;
            flash_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_PLAY;
         frame_q  <= '0;
         period_q <= '0;
         flash_q  <= 1'b1;
         rgb_q    <= '0;
         sel_q    <= SEL_NONE;
      end else begin
         state_q  <= state_d;
         frame_q  <= frame_d;
         period_q <= period_d;
         flash_q  <= flash_d;
         rgb_q    <= rgb_d;
         sel_q    <= sel_d;
      end
   end

   assign bus.RGBOut    = rgb_q;
   assign bus.layerSel  = sel_q;
   assign bus.gameState = state_q;
endmodule

// File: tb/tb_objects_mux_n.sv
// Randomised scoreboard bench for objects_mux_n with a frame-counting game model.
module tb_objects_mux_n;
   localparam int NL = 8;
   localparam int RW = 8;
   localparam int FF = 4;
   localparam int FP = 2;
   localparam int SW = $clog2(NL + 1);
   localparam int EW = RW + SW + 2;
   localparam logic [RW-1:0] FLASH_COL = 8'hFF;

   localparam int M_PLAY   = 0;
   localparam int M_FLASH  = 1;
   localparam int M_SCREEN = 2;

   logic clk;
   logic reset;

   objects_mux_n_if #(.NUM_LAYERS(NL), .RGB_W(RW)) bus ();

   objects_mux_n #(
      .NUM_LAYERS(NL), .RGB_W(RW), .FLASH_FRAMES(FF), .FLASH_PERIOD(FP),
      .FLASH_RGB(FLASH_COL)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [EW-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   // behavioural model: game mode plus number of frame pulses seen in FLASH
   int m_mode   = M_PLAY;
   int m_frames = 0;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   // Compute the response to the inputs currently on the bus, push it, advance one cycle.
   task automatic step();
      int win;
      logic [RW-1:0] col;
      logic [RW-1:0] e_rgb;
      logic [SW-1:0] e_sel;
      bit on;
      win = NL;
      for (int i = NL - 1; i >= 0; i--)
         if (bus.layerDR[i] && bus.layerMask[i]) win = i;
      col = (win < NL) ? bus.layerRGB[win*RW +: RW] : bus.backGroundRGB;
      e_sel = SW'(win);
      if (reset) begin
         e_rgb = '0;
         e_sel = SW'(NL);
         m_mode = M_PLAY;
         m_frames = 0;
      end else if (m_mode == M_PLAY) begin
         e_rgb = col;
         if (bus.gameover) begin
            m_mode = M_FLASH;
            m_frames = 0;
         end
      end else if (m_mode == M_FLASH) begin
         on = ((m_frames / FP) % 2) == 0;
         e_rgb = (win < NL && on) ? FLASH_COL : col;
         if (bus.startOfFrame) begin
            m_frames++;
            if (m_frames == FF) m_mode = M_SCREEN;
         end
      end else begin
         e_rgb = bus.screenDR ? bus.screenRGB : bus.backGroundRGB;
         e_sel = SW'(NL);
         if (bus.restart) m_mode = M_PLAY;
      end
      exp_q.push_back({e_rgb, e_sel, 2'(m_mode)});
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.layerDR = '0;
      bus.layerRGB = '0;
      bus.layerMask = '1;
      bus.backGroundRGB = '0;
      bus.screenDR = 1'b0;
      bus.screenRGB = '0;
      bus.gameover = 1'b0;
      bus.restart = 1'b0;
      bus.startOfFrame = 1'b0;
   endtask

   task automatic rand_pixels();
      bus.layerDR = 8'($urandom) & 8'($urandom);
      bus.layerRGB = {$urandom, $urandom};
      bus.backGroundRGB = 8'($urandom);
      bus.screenDR = 1'($urandom);
      bus.screenRGB = 8'($urandom);
   endtask

   // monitor / scoreboard
   initial begin
      logic [EW-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("RGBOut", int'(bus.RGBOut), int'(e[EW-1 -: RW]));
            chk("layerSel", int'(bus.layerSel), int'(e[SW+1 -: SW]));
            chk("gameState", int'(bus.gameState), int'(e[1:0]));
         end
      end
   end

   // driver
   initial begin
      reset = 1'b1;
      idle_inputs();
      repeat (2) step();
      reset = 1'b0;

      // priority and mask
      bus.layerDR = 8'b0010_0100;
      bus.layerRGB = '0;
      bus.layerRGB[2*RW +: RW] = 8'h1C;
      bus.layerRGB[5*RW +: RW] = 8'hE0;
      step();
      bus.layerMask[2] = 1'b0;
      step();
      bus.layerMask = '1;

      // background only
      bus.layerDR = '0;
      bus.backGroundRGB = 8'h03;
      step();

      // random PLAY pixels
      for (int c = 0; c < 30; c++) begin
         rand_pixels();
         step();
      end

      // game over with a coincident frame pulse that must not count
      idle_inputs();
      bus.layerDR = 8'h01;
      bus.layerRGB[0 +: RW] = 8'h12;
      bus.backGroundRGB = 8'h03;
      bus.gameover = 1'b1;
      bus.startOfFrame = 1'b1;
      step();
      bus.gameover = 1'b0;
      for (int c = 0; c < 60 && m_mode != M_SCREEN; c++) begin
         bus.startOfFrame = (c % 3 == 2);
         bus.gameover = (c % 5 == 1);
         bus.restart = (c % 7 == 3);
         bus.layerDR = (c % 4 == 0) ? 8'h00 : 8'h01;
         step();
      end

      // SCREEN, then restart and gameover together
      idle_inputs();
      for (int c = 0; c < 6; c++) begin
         rand_pixels();
         bus.screenDR = (c != 2);
         bus.screenRGB = 8'h4A;
         bus.gameover = (c == 3);
         step();
      end
      bus.restart = 1'b1;
      bus.gameover = 1'b1;
      step();
      bus.restart = 1'b0;
      step();
      bus.gameover = 1'b0;

      // reset in the middle of FLASH after two frames
      bus.layerDR = 8'h01;
      bus.layerRGB[0 +: RW] = 8'h12;
      for (int c = 0; c < 4; c++) begin
         bus.startOfFrame = (c % 2 == 0);
         step();
      end
      bus.startOfFrame = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();

      // long random run
      for (int c = 0; c < 3000; c++) begin
         rand_pixels();
         bus.layerMask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
         bus.gameover = ($urandom_range(0, 19) == 0);
         bus.restart = ($urandom_range(0, 9) == 0);
         bus.startOfFrame = ($urandom_range(0, 3) == 0);
         reset = ($urandom_range(0, 199) == 0);
         step();
      end
      reset = 1'b0;
      idle_inputs();

      repeat (3) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
